// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, H/V counters, sync, blanking and strobes.
// Define VTG_FLIP_EN to add the frame-latched cocktail flip input.
module video_timing_gen #(
    parameter int CLK_DIV  = 3,
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 304,
    parameter int HS_END   = 336,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 240,
    parameter int VS_END   = 248
) (
    input  logic          clk,
    input  logic          nRESET,
`ifdef VTG_FLIP_EN
    input  logic          flip,
`endif
    output logic          pix_ce,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          csync_n,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    generate
        if (!(H_ACTIVE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL &&
              H_TOTAL <= (1 << HW))) begin : g_bad_h
            $error("video_timing_gen: illegal horizontal timing parameters");
        end
        if (!(V_ACTIVE < VS_START && VS_START < VS_END && VS_END <= V_TOTAL &&
              V_TOTAL <= (1 << VW))) begin : g_bad_v
            $error("video_timing_gen: illegal vertical timing parameters");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("video_timing_gen: CLK_DIV must be 1..16");
        end
    endgenerate

    logic [3:0]    div_q, div_d;
    logic          pix_ce_q, pix_ce_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          csync_n_q, csync_n_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Decode works on the next counter values so flags line up with the counters.
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        pix_ce_d      = (div_q == DIV_LAST);
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d       = '0;
                line_start_d = 1'b1;
                if (vcnt_q == V_LAST) begin
                    vcnt_d        = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
        hsync_n_d = !(int'(hcnt_d) >= HS_START && int'(hcnt_d) < HS_END);
        vsync_n_d = !(int'(vcnt_d) >= VS_START && int'(vcnt_d) < VS_END);
        csync_n_d = hsync_n_d && vsync_n_d;
        hblank_d  = int'(hcnt_d) >= H_ACTIVE;
        vblank_d  = int'(vcnt_d) >= V_ACTIVE;
        de_d      = !hblank_d && !vblank_d;
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            div_q         <= 4'd0;
            pix_ce_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            csync_n_q     <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            csync_n_q     <= csync_n_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VTG_FLIP_EN
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);

    logic flip_q, flip_d;

    // Flip only takes effect at a frame boundary so a frame is never torn.
    always_comb begin
        flip_d = flip_q;
        if (frame_start_d) begin
            flip_d = flip;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= flip_d;
        end
    end

    assign hcount = (flip_q && de_q) ? H_ACT_LAST - hcnt_q : hcnt_q;
    assign vcount = (flip_q && de_q) ? V_ACT_LAST - vcnt_q : vcnt_q;
`else
    assign hcount = hcnt_q;
    assign vcount = vcnt_q;
`endif

    assign pix_ce      = pix_ce_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign csync_n     = csync_n_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: dut 0 uses the default raster, dut 1 a tiny CLK_DIV=1 raster.
module tb_video_timing_gen;

    typedef struct packed {
        logic       ce;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs, vs, cs, hb, vb, de, ls, fs;
    } obs_t;

    typedef struct packed {
        logic       is_rst;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs, vs, cs, hb, vb, de, ls, fs;
        int         ce_cyc;
    } item_t;

`ifdef VTG_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
    logic flip_a, flip_b;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b;
    logic       pce_a, hs_a, vs_a, cs_a, hb_a, vb_a, de_a, ls_a, fs_a;
    logic       pce_b, hs_b, vs_b, cs_b, hb_b, vb_b, de_b, ls_b, fs_b;
    logic [8:0] h_a, v_a, h_b, v_b;
    obs_t       obs_a, obs_b;

    video_timing_gen u_dut_a (
        .clk(clk), .nRESET(rst_n_a),
`ifdef VTG_FLIP_EN
        .flip(flip_a),
`endif
        .pix_ce(pce_a), .hcount(h_a), .vcount(v_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .csync_n(cs_a),
        .hblank(hb_a), .vblank(vb_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .CLK_DIV(1), .HW(9), .VW(9),
        .H_TOTAL(8), .H_ACTIVE(4), .HS_START(5), .HS_END(6),
        .V_TOTAL(4), .V_ACTIVE(2), .VS_START(3), .VS_END(4)
    ) u_dut_b (
        .clk(clk), .nRESET(rst_n_b),
`ifdef VTG_FLIP_EN
        .flip(flip_b),
`endif
        .pix_ce(pce_b), .hcount(h_b), .vcount(v_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .csync_n(cs_b),
        .hblank(hb_b), .vblank(vb_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    assign obs_a = {pce_a, h_a, v_a, hs_a, vs_a, cs_a, hb_a, vb_a, de_a, ls_a, fs_a};
    assign obs_b = {pce_b, h_b, v_b, hs_b, vs_b, cs_b, hb_b, vb_b, de_b, ls_b, fs_b};

    int         vectors = 0;
    int         miscompares = 0;
    item_t      q_a[$];
    item_t      q_b[$];
    int         cyc[2];
    int         last_ce[2];
    logic       prev_ce[2];
    logic [8:0] hold_h[2];
    logic [8:0] hold_v[2];

    function automatic int qsize(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic bit front_rst(input int id);
        if (qsize(id) == 0) return 1'b0;
        return (id == 0) ? q_a[0].is_rst : q_b[0].is_rst;
    endfunction

    task automatic push_item(input int id, input item_t it);
        if (id == 0) q_a.push_back(it);
        else         q_b.push_back(it);
    endtask

    task automatic pop_item(input int id, output item_t it);
        if (id == 0) it = q_a.pop_front();
        else         it = q_b.pop_front();
    endtask

    function automatic item_t make_rst();
        item_t it;
        it        = '0;
        it.is_rst = 1'b1;
        it.hs     = 1'b1;
        it.vs     = 1'b1;
        it.cs     = 1'b1;
        it.de     = 1'b1;
        return it;
    endfunction

    // Expected state after the k-th pixel advance since reset release.
    function automatic item_t make_pix(input int id, input int k);
        item_t it;
        int cd, ht, ha, hss, hse, vt, va, vss, vse, h, v, fr;
        if (id == 0) begin
            cd = 3; ht = 384; ha = 256; hss = 304; hse = 336;
            vt = 264; va = 224; vss = 240; vse = 248;
        end else begin
            cd = 1; ht = 8; ha = 4; hss = 5; hse = 6;
            vt = 4; va = 2; vss = 3; vse = 4;
        end
        h  = k % ht;
        v  = (k / ht) % vt;
        fr = k / (ht * vt);
        it        = '0;
        it.h      = 9'(h);
        it.v      = 9'(v);
        it.hs     = !(h >= hss && h < hse);
        it.vs     = !(v >= vss && v < vse);
        it.cs     = it.hs && it.vs;
        it.hb     = (h >= ha);
        it.vb     = (v >= va);
        it.de     = !it.hb && !it.vb;
        it.ls     = (h == 0);
        it.fs     = (h == 0) && (v == 0);
        it.ce_cyc = cd * k;
        if (FLIP_ON && id == 1 && fr >= 1 && it.de) begin
            it.h = 9'(ha - 1 - h);
            it.v = 9'(va - 1 - v);
        end
        return it;
    endfunction

    task automatic compare_item(input int id, input item_t it, input obs_t o);
        logic [25:0] act, req;
        act = {o.h, o.v, o.hs, o.vs, o.cs, o.hb, o.vb, o.de, o.ls, o.fs};
        req = {it.h, it.v, it.hs, it.vs, it.cs, it.hb, it.vb, it.de, it.ls, it.fs};
        vectors++;
        if (act !== req || (it.is_rst && o.ce !== 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d: actual h=%0d v=%0d hs,vs,cs,hb,vb,de,ls,fs=%b%b%b%b%b%b%b%b ce=%b, required h=%0d v=%0d %b%b%b%b%b%b%b%b",
                     it.is_rst ? "reset" : "pixel", id, o.h, o.v, o.hs, o.vs, o.cs,
                     o.hb, o.vb, o.de, o.ls, o.fs, o.ce, it.h, it.v, it.hs, it.vs,
                     it.cs, it.hb, it.vb, it.de, it.ls, it.fs);
        end
        if (!it.is_rst) begin
            vectors++;
            if (last_ce[id] != it.ce_cyc) begin
                miscompares++;
                $display("[TB] FAIL pix_ce_timing dut%0d: actual clock %0d, required clock %0d",
                         id, last_ce[id], it.ce_cyc);
            end
        end
    endtask

    // Monitor: pops on reset edges and on every pix_ce-qualified edge.
    task automatic checkOutput(input int id, input obs_t o, input logic rn);
        item_t it;
        if (!rn) begin
            cyc[id]     = 0;
            prev_ce[id] = 1'b0;
            if (front_rst(id)) begin
                pop_item(id, it);
                compare_item(id, it, o);
            end
        end else begin
            cyc[id]++;
            if (prev_ce[id]) begin
                if (qsize(id) != 0 && !front_rst(id)) begin
                    pop_item(id, it);
                    compare_item(id, it, o);
                end
            end else begin
                vectors++;
                if (o.h !== hold_h[id] || o.v !== hold_v[id] || o.ls !== 1'b0 || o.fs !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL hold dut%0d: actual h=%0d v=%0d ls=%b fs=%b, required h=%0d v=%0d ls=0 fs=0",
                             id, o.h, o.v, o.ls, o.fs, hold_h[id], hold_v[id]);
                end
            end
            if (o.ce === 1'b1) last_ce[id] = cyc[id];
            prev_ce[id] = o.ce;
        end
        hold_h[id] = o.h;
        hold_v[id] = o.v;
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput(0, obs_a, rst_n_a);
        checkOutput(1, obs_b, rst_n_b);
    end

    task automatic applyStimulus(input int id, input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            push_item(id, make_pix(id, k));
        end
    endtask

    task automatic wait_drain(input int id, input int budget, input string tag);
        int n;
        n = 0;
        while (qsize(id) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (qsize(id) != 0) begin
            miscompares++;
            $display("[TB] FAIL timeout_%s dut%0d: actual %0d items left, required 0", tag, id, qsize(id));
            if (id == 0) q_a.delete();
            else         q_b.delete();
        end
    endtask

    task automatic reset_dut_a();
        push_item(0, make_rst());
        rst_n_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
`ifdef VTG_FLIP_EN
        flip_a = 1'b0;
        flip_b = 1'b0;
`endif
        push_item(0, make_rst());
        push_item(1, make_rst());
        repeat (2) @(negedge clk);

        $display("[TB] default raster from reset release, past first line wrap");
        applyStimulus(0, 1, 400);
        rst_n_a = 1'b1;
        wait_drain(0, 1400, "release");

        $display("[TB] reset asserted at hcount 310 inside hsync");
        reset_dut_a();
        applyStimulus(0, 1, 310);
        rst_n_a = 1'b1;
        wait_drain(0, 1100, "to310");
        reset_dut_a();
        applyStimulus(0, 1, 390);
        rst_n_a = 1'b1;
        wait_drain(0, 1300, "restart");

        $display("[TB] small raster, CLK_DIV=1, three frames");
        applyStimulus(1, 1, 96);
        rst_n_b = 1'b1;
        repeat (10) @(negedge clk);
`ifdef VTG_FLIP_EN
        flip_b = 1'b1;
`endif
        wait_drain(1, 200, "small");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
